// File: rtl/conversor_binario_bcd.sv
// conversor_binario_bcd: sequential double-dabble binary-to-BCD converter with optional leading-zero blanking
module conversor_binario_bcd #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [LARGURA-1:0]     binario,
  input  logic                   apagar_zeros,
  output logic [4*DIGITOS-1:0]   bcd_digitos,
  output logic                   pronto,
  output logic                   ocupado
);
  localparam int CW = $clog2(LARGURA + 1);
  localparam int BW = 4 * DIGITOS;
  typedef enum logic [1:0] {OCIOSO, DESLOCA, FINALIZA} estado_t;
  estado_t estado_q, estado_d;
  logic [LARGURA-1:0] binario_q, binario_d;
  logic [BW-1:0] rascunho_q, rascunho_d, bcd_q, bcd_d;
  logic [CW-1:0] cont_q, cont_d;
  logic apagar_q, apagar_d, pronto_q, pronto_d;

  function automatic logic [BW-1:0] corrige(input logic [BW-1:0] v);
    corrige = v;
    for (int i = 0; i < DIGITOS; i++)
      corrige[4*i+:4] = (v[4*i+:4] >= 4'd5) ? v[4*i+:4] + 4'd3 : v[4*i+:4];
  endfunction

  // Zeros above the most significant nonzero digit become 4'hF; units always shown
  function automatic logic [BW-1:0] apaga(input logic [BW-1:0] v);
    logic visivel;
    apaga = v;
    visivel = 1'b0;
    for (int i = DIGITOS - 1; i > 0; i--) begin
      if (v[4*i+:4] != 4'd0) visivel = 1'b1;
      apaga[4*i+:4] = visivel ? v[4*i+:4] : 4'hF;
    end
  endfunction

  always_comb begin
    estado_d   = estado_q;
    binario_d  = binario_q;
    rascunho_d = rascunho_q;
    cont_d     = cont_q;
    apagar_d   = apagar_q;
    bcd_d      = bcd_q;
    pronto_d   = 1'b0;
    case (estado_q)
      OCIOSO: if (iniciar) begin
        binario_d  = binario;
        rascunho_d = '0;
        cont_d     = CW'(LARGURA);
        apagar_d   = apagar_zeros;
        estado_d   = DESLOCA;
      end
      DESLOCA: begin
        {rascunho_d, binario_d} = {corrige(rascunho_q), binario_q} << 1;
        cont_d   = cont_q - CW'(1);
        estado_d = (cont_q == CW'(1)) ? FINALIZA : DESLOCA;
      end
      FINALIZA: begin
        bcd_d    = apagar_q ? apaga(rascunho_q) : rascunho_q;
        pronto_d = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      binario_q  <= '0;
      rascunho_q <= '0;
      cont_q     <= '0;
      apagar_q   <= 1'b0;
      bcd_q      <= '0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      binario_q  <= binario_d;
      rascunho_q <= rascunho_d;
      cont_q     <= cont_d;
      apagar_q   <= apagar_d;
      bcd_q      <= bcd_d;
      pronto_q   <= pronto_d;
    end
  end

  assign bcd_digitos = bcd_q;
  assign pronto      = pronto_q;
  assign ocupado     = (estado_q != OCIOSO);
endmodule

// File: doc/conversor_binario_bcd.md
# conversor_binario_bcd

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the per-digit seven-segment decoders. Each 4-bit slice of `bcd_digitos` drives one decoder's `bcd` input. Optional leading-zero blanking emits code 4'hF, which the decoder maps to all segments off.

## Interface
Parameters:
- `LARGURA`, default 16: width of the unsigned binary input.
- `DIGITOS`, default 5: number of BCD digits. Must satisfy 10^DIGITOS > 2^LARGURA.

Ports:
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `iniciar`, input, 1: start request; sampled only in state OCIOSO.
- `binario`, input, LARGURA: unsigned value; captured on the accepting edge.
- `apagar_zeros`, input, 1: leading-zero blanking enable; captured on the accepting edge.
- `bcd_digitos`, output, 4*DIGITOS: result, registered. Digit i (units = 0) is bits [4i+3:4i].
- `pronto`, output, 1: one-cycle registered pulse; marks the edge on which `bcd_digitos` updated.
- `ocupado`, output, 1: high while a conversion is in progress (state != OCIOSO).

## Operation
- **Internal registers:**
  - Shift register `binario_r` (LARGURA bits).
  - Scratch BCD register (4*DIGITOS bits).
  - Down-counter (ceil(log2(LARGURA+1)) bits).
  - Captured blanking flag.
- **State machine:** OCIOSO, DESLOCA, FINALIZA.
- **OCIOSO:**
  - If `iniciar`=1: load `binario_r`←`binario`, clear scratch, counter←LARGURA, latch `apagar_zeros`, go to DESLOCA.
  - Otherwise hold.
- **DESLOCA, every edge:**
  - Add 3 to each scratch nibble whose value ≥5. This correction is combinational on the current scratch.
  - Shift {scratch, `binario_r`} left by one bit as a single concatenation; the MSB of `binario_r` enters scratch bit 0.
  - Decrement the counter. On the edge where the counter goes 1→0, go to FINALIZA.
- **FINALIZA, one edge:**
  - Copy scratch to `bcd_digitos`, applying blanking if the latched flag is set.
  - Set `pronto`=1 and go to OCIOSO.
- **Blanking:**
  - Scanning from the most-significant digit down, each digit equal to 0 becomes 4'hF until the first nonzero digit.
  - Digit 0 is never blanked, so value 0 displays as a single "0".
- **`iniciar` while busy:** ignored; the request is not queued.
- **`binario`/`apagar_zeros` changes after the accepting edge:** no effect on the running conversion.
- **`bcd_digitos` between conversions:** holds the last result.

## Timing
- **Reset values:** state OCIOSO, `bcd_digitos`=0 (all digits 0, no blanking), `pronto`=0, `ocupado`=0, all internal registers 0.
- **Reset mid-conversion:** aborts immediately and asynchronously. Outputs take their reset values, and no `pronto` pulse is produced for the aborted conversion.
- **Latency (accepting edge = edge 0):**
  - Shifts occur on edges 1..LARGURA.
  - `bcd_digitos` updates and `pronto` rises on edge LARGURA+1 (edge 17 for the default).
  - `pronto` falls on edge LARGURA+2.
- **`ocupado`:** high from just after edge 0 through edge LARGURA+1, i.e. LARGURA+1 cycles.
- **Back-to-back:** `iniciar` high in the cycle where `pronto`=1 is accepted on edge LARGURA+2. Sustained throughput is one conversion per LARGURA+2 cycles.
- **No combinational path** from any input to any output.

## Test plan
1. **Reset and zero:**
   - After reset, `bcd_digitos`=0x00000, `pronto`=0, `ocupado`=0.
   - `binario`=0, `apagar_zeros`=0 → 0x00000.
   - Same with `apagar_zeros`=1 → 0xFFFF0.
2. **Maximum value:** `binario`=65535, `apagar_zeros`=0 → 0x65535, with `pronto` high exactly on edge 17 after the accepting edge, for one cycle.
3. **Blanking:**
   - 1234 with `apagar_zeros`=1 → 0xF1234.
   - 7 → 0xFFFF7.
   - 10000 → 0x10000 (inner zeros not blanked).
4. **Busy ignore and hold:**
   - Start 999; pulse `iniciar` with `binario`=42 on edge 5 → result 0x00999 only, with a single `pronto` pulse.
   - Change `binario` mid-run → no effect on the result.
5. **Back-to-back:**
   - Hold `iniciar`=1 with 321 then 4096 → 0x00321 then 0x04096.
   - The two `pronto` pulses are 18 cycles apart.
6. **Reset mid-conversion:**
   - Assert `reset` on cycle 8 of converting 54321 → outputs zero immediately and no `pronto`.
   - A new conversion of 54321 after release → 0x54321.
